gpio_ctrl_param: RTL and testbench
==================================

Name: gpio_ctrl_param

Overview:
Parametrised GPIO controller, the next generation of the team's fixed 32-pin GPIO block. It is a memory-mapped slave on the core's simple peripheral bus and provides:
- per-pin direction control;
- atomic set/clear/toggle of outputs;
- synchronised input sampling;
- per-pin edge-detect interrupts with write-1-to-clear status and a single level interrupt line to the core.

Parameters:
N_PINS, 32, number of GPIO pins (1..32); register bits [31:N_PINS] read 0 and ignore writes
SYNC_STAGES, 2, flops in the input synchroniser chain (2..4)
ADDR_W, 8, width of the byte-address offset decoded by the block

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
gpio_en  input  1  block select from the address decoder; a transaction occurs on a cycle with gpio_en=1
write_enable  input  1  1=write, 0=read; sampled with gpio_en
gpio_addr  input  ADDR_W  byte offset; bits [1:0] ignored
gpio_wdata  input  32  write data
gpio_rdata  output  32  registered read data
gpio_ready  output  1  one-cycle pulse acknowledging every transaction
gpio_in  input  N_PINS  external pin levels, asynchronous to clk
gpio_out  output  N_PINS  driven output values
gpio_oe  output  N_PINS  output enables (1=drive)
gpio_irq  output  1  OR of (IRQ_STATUS & IRQ_EN)

Behaviour:
- Reset: rst_n low asynchronously clears all registers, the synchroniser and the edge-history flops. Outputs: gpio_out=0, gpio_oe=0, gpio_rdata=0, gpio_ready=0, gpio_irq=0.
- Register map (offsets):
  - 0x00 DATA_OUT, RW. Drives gpio_out.
  - 0x04 DIR, RW. Drives gpio_oe directly.
  - 0x08 DATA_IN, RO. Per bit: DIR=0 gives the synchronised pin; DIR=1 gives DATA_OUT.
  - 0x0C SET, WO. DATA_OUT |= wdata.
  - 0x10 CLR, WO. DATA_OUT &= ~wdata.
  - 0x14 TOGGLE, WO. DATA_OUT ^= wdata.
  - 0x18 IRQ_EN, RW.
  - 0x1C IRQ_POL, RW. 0=rising edge, 1=falling edge.
  - 0x20 IRQ_STATUS, RW1C.
  - Reads of the write-only offsets (0x0C, 0x10, 0x14) and of unmapped offsets return 0. Writes to unmapped offsets and to DATA_IN are ignored. All of these still acknowledge.
- Handshake: a transaction is accepted on any cycle with gpio_en=1.
  - gpio_ready goes high the following cycle for exactly one cycle.
  - gpio_rdata updates in that same cycle and holds its value until the next read.
  - Back-to-back transactions are allowed every cycle; each one produces its own ready pulse.
- Write effects are visible in register state, and on gpio_out/gpio_oe, the cycle after acceptance.
- Input path:
  - gpio_in passes through SYNC_STAGES flops, giving sync_in.
  - prev_in registers sync_in.
  - Edge detection: rise = sync_in & ~prev_in; fall = ~sync_in & prev_in.
  - Pin-to-DATA_IN latency is SYNC_STAGES cycles.
- Interrupt status per bit i:
  - Bit i sets when DIR[i]=0, IRQ_EN[i]=1 and the edge selected by IRQ_POL[i] is detected.
  - Bit i stays set until a 1 is written to it.
  - If a new edge and a W1C of the same bit land in the same cycle, set wins and the bit stays 1.
  - Pins configured as outputs never set status.
  - Clearing IRQ_EN does not clear existing status bits, but it masks them from gpio_irq.
- gpio_irq is registered and asserts one cycle after the status/enable condition becomes true.
- Changing IRQ_POL does not create a spurious edge; detection is always based on sync_in vs prev_in.
- Reset asserted mid-transaction: no ready pulse is produced and the write is lost.
- Bits at or above N_PINS are tied to 0 in every register.

Test Plan:
- Reset, then read offsets 0x00 through 0x20 -> every read returns 0, each gpio_ready pulse is 1 cycle wide, gpio_oe=0.
- Write DIR=0x0000_00FF, DATA_OUT=0x0000_00A5; SET 0x0000_0100; CLR 0x0000_0005; TOGGLE 0x0000_00F0 -> gpio_out=0x0000_0150, gpio_oe=0x0000_00FF, DATA_IN[7:0]=0x50.
- DIR=0; drive gpio_in=0x0000_1234 -> DATA_IN reads 0x0000_1234 only once SYNC_STAGES cycles have elapsed; a read issued earlier returns the old value.
- IRQ_EN=0x3, IRQ_POL=0x2; pulse pin0 0->1 and pin1 1->0 -> IRQ_STATUS=0x3 and gpio_irq=1; write 0x1 to IRQ_STATUS -> status=0x2 and irq stays 1; write 0x2 -> irq=0.
- W1C to bit0 issued in the same cycle a new rising edge on pin0 is detected -> IRQ_STATUS[0] remains 1.
- N_PINS=8 build: write 0xFFFF_FFFF to DATA_OUT and DIR -> both read back 0x0000_00FF; a write to offset 0x40 is ignored but acknowledged, and a read of 0x40 returns 0.

Source files
------------

// File: rtl/gpio_ctrl_param.sv
// Parametrised GPIO controller: direction, atomic set/clear/toggle, synchronised inputs,
// per-pin edge interrupts with W1C status and a registered level interrupt.
module gpio_ctrl_param #(
    parameter int unsigned N_PINS      = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gpio_en,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] gpio_addr,
    input  logic [31:0]       gpio_wdata,
    output logic [31:0]       gpio_rdata,
    output logic              gpio_ready,
    input  logic [N_PINS-1:0] gpio_in,
    output logic [N_PINS-1:0] gpio_out,
    output logic [N_PINS-1:0] gpio_oe,
    output logic              gpio_irq
);

    localparam logic [31:0] W_DATA_OUT   = 32'd0;
    localparam logic [31:0] W_DIR        = 32'd1;
    localparam logic [31:0] W_DATA_IN    = 32'd2;
    localparam logic [31:0] W_SET        = 32'd3;
    localparam logic [31:0] W_CLR        = 32'd4;
    localparam logic [31:0] W_TOGGLE     = 32'd5;
    localparam logic [31:0] W_IRQ_EN     = 32'd6;
    localparam logic [31:0] W_IRQ_POL    = 32'd7;
    localparam logic [31:0] W_IRQ_STATUS = 32'd8;

    logic [N_PINS-1:0] data_out_q, data_out_d;
    logic [N_PINS-1:0] dir_q, dir_d;
    logic [N_PINS-1:0] irq_en_q, irq_en_d;
    logic [N_PINS-1:0] irq_pol_q, irq_pol_d;
    logic [N_PINS-1:0] irq_status_q, irq_status_d;
    logic [N_PINS-1:0] prev_in_q, prev_in_d;
    logic [SYNC_STAGES-1:0][N_PINS-1:0] sync_q, sync_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              irq_q, irq_d;

    logic [N_PINS-1:0] sync_in, data_in, rise, fall, edge_hit, wbits, w1c;
    logic [31:0]       word_idx;
    logic              wr, rd;

    // Address bits [1:0] and write-data bits above N_PINS are intentionally ignored.
    logic unused_bits;
    assign unused_bits = &{1'b0, gpio_addr[1:0], gpio_wdata};

    function automatic logic [31:0] pad(input logic [N_PINS-1:0] v);
        pad = '0;
        pad[N_PINS-1:0] = v;
    endfunction

    always_comb begin
        word_idx = '0;
        word_idx[ADDR_W-3:0] = gpio_addr[ADDR_W-1:2];
    end

    assign wr    = gpio_en & write_enable;
    assign rd    = gpio_en & ~write_enable;
    assign wbits = gpio_wdata[N_PINS-1:0];

    assign sync_in  = sync_q[SYNC_STAGES-1];
    assign data_in  = (dir_q & data_out_q) | (~dir_q & sync_in);
    assign rise     = sync_in & ~prev_in_q;
    assign fall     = ~sync_in & prev_in_q;
    assign edge_hit = ~dir_q & irq_en_q & ((irq_pol_q & fall) | (~irq_pol_q & rise));

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], gpio_in};
        prev_in_d = sync_in;
    end

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        irq_pol_d  = irq_pol_q;
        w1c        = '0;
        if (wr) begin
            case (word_idx)
                W_DATA_OUT:   data_out_d = wbits;
                W_DIR:        dir_d      = wbits;
                W_SET:        data_out_d = data_out_q | wbits;
                W_CLR:        data_out_d = data_out_q & ~wbits;
                W_TOGGLE:     data_out_d = data_out_q ^ wbits;
                W_IRQ_EN:     irq_en_d   = wbits;
                W_IRQ_POL:    irq_pol_d  = wbits;
                W_IRQ_STATUS: w1c        = wbits;
                default:      ;
            endcase
        end
        // A fresh edge overrides a same-cycle W1C of that bit.
        irq_status_d = (irq_status_q & ~w1c) | edge_hit;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd) begin
            case (word_idx)
                W_DATA_OUT:   rdata_d = pad(data_out_q);
                W_DIR:        rdata_d = pad(dir_q);
                W_DATA_IN:    rdata_d = pad(data_in);
                W_IRQ_EN:     rdata_d = pad(irq_en_q);
                W_IRQ_POL:    rdata_d = pad(irq_pol_q);
                W_IRQ_STATUS: rdata_d = pad(irq_status_q);
                default:      rdata_d = '0;
            endcase
        end
        ready_d = gpio_en;
        irq_d   = |(irq_status_q & irq_en_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q   <= '0;
            dir_q        <= '0;
            irq_en_q     <= '0;
            irq_pol_q    <= '0;
            irq_status_q <= '0;
            prev_in_q    <= '0;
            sync_q       <= '0;
            rdata_q      <= '0;
            ready_q      <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            dir_q        <= dir_d;
            irq_en_q     <= irq_en_d;
            irq_pol_q    <= irq_pol_d;
            irq_status_q <= irq_status_d;
            prev_in_q    <= prev_in_d;
            sync_q       <= sync_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
            irq_q        <= irq_d;
        end
    end

    assign gpio_out   = data_out_q;
    assign gpio_oe    = dir_q;
    assign gpio_rdata = rdata_q;
    assign gpio_ready = ready_q;
    assign gpio_irq   = irq_q;

endmodule

// File: tb/tb_gpio_ctrl_param.sv
// Bench for gpio_ctrl_param: a 32-pin instance checked every cycle against a behavioural
// model, plus an 8-pin / 3-stage instance checked with directed literal expectations.
module tb_gpio_ctrl_param;

    localparam int unsigned S_MAIN = 2;

    logic        clk, rst_n;
    logic        en, we;
    logic [7:0]  addr;
    logic [31:0] wdata, rdata, pin, out, oe;
    logic        ready, irq;

    logic        en8, we8;
    logic [7:0]  addr8;
    logic [31:0] wdata8, rdata8;
    logic [7:0]  pin8, out8, oe8;
    logic        ready8, irq8;

    int checks = 0;
    int errors = 0;
    bit done   = 0;

    gpio_ctrl_param #(.N_PINS(32), .SYNC_STAGES(S_MAIN), .ADDR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .gpio_en(en), .write_enable(we), .gpio_addr(addr),
        .gpio_wdata(wdata), .gpio_rdata(rdata), .gpio_ready(ready), .gpio_in(pin),
        .gpio_out(out), .gpio_oe(oe), .gpio_irq(irq)
    );

    gpio_ctrl_param #(.N_PINS(8), .SYNC_STAGES(3), .ADDR_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .gpio_en(en8), .write_enable(we8), .gpio_addr(addr8),
        .gpio_wdata(wdata8), .gpio_rdata(rdata8), .gpio_ready(ready8), .gpio_in(pin8),
        .gpio_out(out8), .gpio_oe(oe8), .gpio_irq(irq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the 32-pin instance ----------------
    logic [31:0] m_out, m_dir, m_en, m_pol, m_st, m_rdata;
    logic        m_ready, m_irq;
    logic [31:0] hist [0:7];   // pin levels seen at past rising edges, [0] = newest

    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] lvl, lvl_before, din, hit, w1c;
        if (!rst_n) begin
            m_out = 0; m_dir = 0; m_en = 0; m_pol = 0; m_st = 0;
            m_rdata = 0; m_ready = 0; m_irq = 0;
            for (int i = 0; i < 8; i++) hist[i] = 0;
        end else begin
            // the block sees pin levels S_MAIN edges late
            lvl        = hist[S_MAIN-1];
            lvl_before = hist[S_MAIN];
            hit = 0;
            for (int i = 0; i < 32; i++) begin
                din[i] = m_dir[i] ? m_out[i] : lvl[i];
                if (!m_dir[i] && m_en[i] &&
                    ((m_pol[i] && lvl_before[i] && !lvl[i]) ||
                     (!m_pol[i] && !lvl_before[i] && lvl[i])))
                    hit[i] = 1'b1;
            end
            m_irq   = (m_st & m_en) != 0;
            m_ready = en;
            if (en && !we) begin
                case ({addr[7:2], 2'b00})
                    8'h00:   m_rdata = m_out;
                    8'h04:   m_rdata = m_dir;
                    8'h08:   m_rdata = din;
                    8'h18:   m_rdata = m_en;
                    8'h1C:   m_rdata = m_pol;
                    8'h20:   m_rdata = m_st;
                    default: m_rdata = 0;
                endcase
            end
            w1c = 0;
            if (en && we) begin
                case ({addr[7:2], 2'b00})
                    8'h00:   m_out = wdata;
                    8'h04:   m_dir = wdata;
                    8'h0C:   m_out = m_out | wdata;
                    8'h10:   m_out = m_out & ~wdata;
                    8'h14:   m_out = m_out ^ wdata;
                    8'h18:   m_en  = wdata;
                    8'h1C:   m_pol = wdata;
                    8'h20:   w1c   = wdata;
                    default: ;
                endcase
            end
            m_st = (m_st & ~w1c) | hit;
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = pin;
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            chk("cyc_out",   out,          m_out);
            chk("cyc_oe",    oe,           m_dir);
            chk("cyc_irq",   32'(irq),     32'(m_irq));
            chk("cyc_ready", 32'(ready),   32'(m_ready));
            chk("cyc_rdata", rdata,        m_rdata);
        end
    end

    // ---------------- bus helpers (called at a falling edge) ----------------
    task automatic xfer(input bit b8, input logic w, input logic [7:0] a,
                        input logic [31:0] d, output logic [31:0] r);
        if (b8) begin en8 = 1; we8 = w; addr8 = a; wdata8 = d; end
        else    begin en  = 1; we  = w; addr  = a; wdata  = d; end
        @(negedge clk);
        en = 0; we = 0; en8 = 0; we8 = 0;
        chk(b8 ? "ready8" : "ready", 32'(b8 ? ready8 : ready), 32'd1);
        r = b8 ? rdata8 : rdata;
    endtask

    task automatic wr(input bit b8, input logic [7:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        xfer(b8, 1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input bit b8, input string name, input logic [7:0] a,
                          input logic [31:0] exp);
        logic [31:0] v;
        xfer(b8, 1'b0, a, 32'd0, v);
        chk(name, v, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; en = 0; we = 0; addr = 0; wdata = 0; pin = 0;
        en8 = 0; we8 = 0; addr8 = 0; wdata8 = 0; pin8 = 0;
        idle(3);
        chk("rst_out", out, 32'h0);
        chk("rst_oe", oe, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_out8", 32'(out8), 32'h0);
        rst_n = 1;

        for (int i = 0; i <= 8; i++) begin
            rd_chk(0, "rst_read", 8'(i * 4), 32'h0);
            idle(1);
            chk("ready_width", 32'(ready), 32'h0);
        end
        chk("rst_oe_after", oe, 32'h0);

        // direction and atomic output operations
        wr(0, 8'h04, 32'h0000_00FF);
        wr(0, 8'h00, 32'h0000_00A5);
        wr(0, 8'h0C, 32'h0000_0100);
        wr(0, 8'h10, 32'h0000_0005);
        wr(0, 8'h14, 32'h0000_00F0);
        chk("out_after_ops", out, 32'h0000_0150);
        chk("oe_after_ops", oe, 32'h0000_00FF);
        rd_chk(0, "data_in_mixed", 8'h08, 32'h0000_0050);
        rd_chk(0, "read_wo_set", 8'h0C, 32'h0);
        wr(0, 8'h40, 32'hFFFF_FFFF);
        rd_chk(0, "read_unmapped", 8'h40, 32'h0);
        rd_chk(0, "data_out_kept", 8'h00, 32'h0000_0150);

        // input synchroniser latency
        wr(0, 8'h04, 32'h0);
        pin = 32'h0000_1234;
        rd_chk(0, "din_early1", 8'h08, 32'h0);
        rd_chk(0, "din_early2", 8'h08, 32'h0);
        rd_chk(0, "din_synced", 8'h08, 32'h0000_1234);

        // edge interrupts, masking and W1C
        pin = 32'h2;
        idle(4);
        wr(0, 8'h18, 32'h3);
        wr(0, 8'h1C, 32'h2);
        pin = 32'h1;
        idle(5);
        rd_chk(0, "irq_status_both", 8'h20, 32'h3);
        chk("irq_on", 32'(irq), 32'h1);
        wr(0, 8'h18, 32'h0);
        idle(1);
        chk("irq_masked", 32'(irq), 32'h0);
        rd_chk(0, "status_kept_masked", 8'h20, 32'h3);
        wr(0, 8'h18, 32'h3);
        idle(1);
        chk("irq_unmasked", 32'(irq), 32'h1);
        wr(0, 8'h20, 32'h1);
        rd_chk(0, "status_after_w1c0", 8'h20, 32'h2);
        chk("irq_still_on", 32'(irq), 32'h1);
        wr(0, 8'h20, 32'h2);
        idle(1);
        chk("irq_off", 32'(irq), 32'h0);

        // W1C landing in the same cycle as a new rising edge on pin0
        pin = 32'h0;
        idle(4);
        rd_chk(0, "status_clear", 8'h20, 32'h0);
        pin = 32'h1;
        idle(2);
        wr(0, 8'h20, 32'h1);
        rd_chk(0, "set_beats_w1c", 8'h20, 32'h1);
        wr(0, 8'h20, 32'h1);

        // reset asserted during a write transaction
        en = 1; we = 1; addr = 8'h00; wdata = 32'hDEAD_BEEF;
        #2 rst_n = 0;
        @(negedge clk);
        en = 0; we = 0;
        chk("rst_mid_ready", 32'(ready), 32'h0);
        chk("rst_mid_out", out, 32'h0);
        rst_n = 1;
        rd_chk(0, "rst_mid_lost", 8'h00, 32'h0);
        rd_chk(0, "rst_mid_status", 8'h20, 32'h0);

        // 8-pin, 3-stage instance
        wr(1, 8'h00, 32'hFFFF_FFFF);
        wr(1, 8'h04, 32'hFFFF_FFFF);
        rd_chk(1, "n8_data_out", 8'h00, 32'h0000_00FF);
        rd_chk(1, "n8_dir", 8'h04, 32'h0000_00FF);
        chk("n8_out", 32'(out8), 32'h0000_00FF);
        chk("n8_oe", 32'(oe8), 32'h0000_00FF);
        wr(1, 8'h40, 32'h1234_5678);
        rd_chk(1, "n8_unmapped", 8'h40, 32'h0);
        rd_chk(1, "n8_data_out_kept", 8'h00, 32'h0000_00FF);
        wr(1, 8'h04, 32'h0);
        pin8 = 8'h5A;
        rd_chk(1, "n8_din_early1", 8'h08, 32'h0);
        rd_chk(1, "n8_din_early2", 8'h08, 32'h0);
        rd_chk(1, "n8_din_early3", 8'h08, 32'h0);
        rd_chk(1, "n8_din_synced", 8'h08, 32'h0000_005A);
        chk("n8_irq", 32'(irq8), 32'h0);

        idle(2);
        done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
